// File: rtl/mux_n_pipe_if.sv
// mux_n_pipe_if: handshake and data bundle for the N-way registered select stage.
// Latency: n/a (wires only).
// Backpressure: ready_o/ready_i carry the upstream and downstream valid/ready handshakes.
// Ports: upstream side data_i/select_i/valid_i/ready_o/flush_i; downstream side
//        data_o/valid_o/ready_i; sticky sel_err_o status.
// The slave modport is the stage's view; master is the environment's view.
interface mux_n_pipe_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] data_i;
  logic [SEL_W-1:0]        select_i;
  logic                    valid_i;
  logic                    ready_o;
  logic                    flush_i;
  logic [WIDTH-1:0]        data_o;
  logic                    valid_o;
  logic                    ready_i;
  logic                    sel_err_o;

  modport slave (
    input  data_i, select_i, valid_i, flush_i, ready_i,
    output ready_o, data_o, valid_o, sel_err_o
  );

  modport master (
    output data_i, select_i, valid_i, flush_i, ready_i,
    input  ready_o, data_o, valid_o, sel_err_o
  );
endinterface

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-way operand select feeding a two-entry (output + skid) register stage.
// Latency: one cycle from accepted word to data_o/valid_o; no combinational data path.
// Backpressure: ready_o = !skid_valid (registered only); a stalled output parks one word in the skid.
// Ports: clk_i rising-edge clock; rst_i async active-low reset; bus (mux_n_pipe_if.slave)
//        carries data_i/select_i/valid_i/ready_o/flush_i upstream and data_o/valid_o/ready_i downstream.
// Optional: define MUXN_SEL_CHECK_EN to build the sticky out-of-range select flag on sel_err_o.
module mux_n_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mux_n_pipe_if.slave   bus
);
  localparam int SEL_W = $clog2(NUM_IN);

  // State code is {skid_valid, valid_o}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] sel_word;
  logic             skid_valid;
  logic             accept;
  logic             send;
  logic             load_out_sel;   // data_o <= selected input word
  logic             load_out_skid;  // data_o <= skid word
  logic             load_skid;      // skid <= selected input word

  assign skid_valid  = state_q[1];
  assign bus.valid_o = state_q[0];
  assign bus.ready_o = ~skid_valid;
  assign bus.data_o  = data_q;

  assign accept = bus.valid_i & ~skid_valid;
  assign send   = state_q[0] & bus.ready_i;

  // Select mux; indices with no matching input fall through to zero.
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.select_i == SEL_W'(k)) begin
        sel_word = bus.data_i[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush wins over accept and send; data registers are left untouched by it.
  always_comb begin
    state_d       = state_q;
    load_out_sel  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (bus.flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d      = ONE;
            load_out_sel = 1'b1;
          end
        end
        ONE: begin
          if (accept && send) begin
            load_out_sel = 1'b1;
          end else if (accept) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (send) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (send) begin
            state_d       = ONE;
            load_out_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_out_sel) begin
        data_q <= sel_word;
      end else if (load_out_skid) begin
        data_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= sel_word;
      end
    end
  end

`ifdef MUXN_SEL_CHECK_EN
  // Sticky until reset; flush deliberately does not clear it.
  logic sel_err_q;
  logic sel_oor;

  assign sel_oor = ({1'b0, bus.select_i} >= (SEL_W+1)'(NUM_IN));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sel_err_q <= 1'b0;
    end else if (accept && sel_oor) begin
      sel_err_q <= 1'b1;
    end
  end

  assign bus.sel_err_o = sel_err_q;
`else
  assign bus.sel_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// tb_mux_n_pipe: directed checks of mux_n_pipe with a 4-input and a 3-input instance.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: ready_i driven directly to exercise ONE/FULL stalls.
module tb_mux_n_pipe;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mux_n_pipe_if #(.WIDTH(32), .NUM_IN(4)) bus4 ();
  mux_n_pipe_if #(.WIDTH(32), .NUM_IN(3)) bus3 ();

  mux_n_pipe #(.WIDTH(32), .NUM_IN(4)) u4 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus4)
  );

  mux_n_pipe #(.WIDTH(32), .NUM_IN(3)) u3 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus3)
  );

`ifdef MUXN_SEL_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus4.data_i   = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    bus4.select_i = '0;
    bus4.valid_i  = 1'b0;
    bus4.flush_i  = 1'b0;
    bus4.ready_i  = 1'b1;
    bus3.data_i   = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    bus3.select_i = '0;
    bus3.valid_i  = 1'b0;
    bus3.flush_i  = 1'b0;
    bus3.ready_i  = 1'b1;

    // Reset state
    #1;
    check("rst_valid", 32'(bus4.valid_o), 32'h0);
    check("rst_data", bus4.data_o, 32'h0);
    check("rst_ready", 32'(bus4.ready_o), 32'h1);
    check("rst_selerr", 32'(bus3.sel_err_o), 32'h0);
    #11 rst_n = 1'b1;
    tick();

    // 1: single word, select 2
    bus4.select_i = 2'd2; bus4.valid_i = 1'b1;
    tick();
    check("t1_data", bus4.data_o, 32'hCCCC0002);
    check("t1_valid", 32'(bus4.valid_o), 32'h1);
    bus4.valid_i = 1'b0;
    tick();
    check("t1_drain", 32'(bus4.valid_o), 32'h0);

    // 2: back-to-back stream
    bus4.valid_i = 1'b1;
    bus4.select_i = 2'd0; tick();
    check("t2_d0", bus4.data_o, 32'hAAAA0000);
    check("t2_r0", 32'(bus4.ready_o), 32'h1);
    bus4.select_i = 2'd1; tick();
    check("t2_d1", bus4.data_o, 32'hBBBB0001);
    check("t2_r1", 32'(bus4.ready_o), 32'h1);
    bus4.select_i = 2'd2; tick();
    check("t2_d2", bus4.data_o, 32'hCCCC0002);
    bus4.select_i = 2'd3; tick();
    check("t2_d3", bus4.data_o, 32'hDDDD0003);
    check("t2_v3", 32'(bus4.valid_o), 32'h1);
    bus4.valid_i = 1'b0; tick();
    check("t2_drain", 32'(bus4.valid_o), 32'h0);

    // 3: backpressure into FULL, then drain in order
    bus4.ready_i = 1'b0; bus4.valid_i = 1'b1;
    bus4.select_i = 2'd1; tick();
    check("t3_one_data", bus4.data_o, 32'hBBBB0001);
    check("t3_one_ready", 32'(bus4.ready_o), 32'h1);
    bus4.select_i = 2'd3; tick();
    check("t3_full_ready", 32'(bus4.ready_o), 32'h0);
    check("t3_full_data", bus4.data_o, 32'hBBBB0001);
    bus4.select_i = 2'd0; tick();  // offered while ready_o=0: ignored
    check("t3_hold_data", bus4.data_o, 32'hBBBB0001);
    check("t3_hold_ready", 32'(bus4.ready_o), 32'h0);
    bus4.valid_i = 1'b0; bus4.ready_i = 1'b1; tick();
    check("t3_second_data", bus4.data_o, 32'hDDDD0003);
    check("t3_second_valid", 32'(bus4.valid_o), 32'h1);
    check("t3_second_ready", 32'(bus4.ready_o), 32'h1);
    tick();
    check("t3_empty", 32'(bus4.valid_o), 32'h0);
    tick();
    check("t3_no_third", 32'(bus4.valid_o), 32'h0);

    // 4: flush while FULL with a word offered
    bus4.ready_i = 1'b0; bus4.valid_i = 1'b1;
    bus4.select_i = 2'd0; tick();
    bus4.select_i = 2'd1; tick();
    check("t4_full", 32'(bus4.ready_o), 32'h0);
    bus4.flush_i = 1'b1; bus4.select_i = 2'd2; tick();
    check("t4_flush_valid", 32'(bus4.valid_o), 32'h0);
    check("t4_flush_ready", 32'(bus4.ready_o), 32'h1);
    bus4.flush_i = 1'b0; bus4.valid_i = 1'b0; bus4.ready_i = 1'b1; tick();
    check("t4_after1", 32'(bus4.valid_o), 32'h0);
    tick();
    check("t4_after2", 32'(bus4.valid_o), 32'h0);

    // 5: NUM_IN=3, out-of-range select
    bus3.valid_i = 1'b1; bus3.select_i = 2'd1; tick();
    check("t5_inrange_data", bus3.data_o, 32'hBBBB0001);
    check("t5_inrange_err", 32'(bus3.sel_err_o), 32'h0);
    bus3.select_i = 2'd3; tick();
    check("t5_oor_data", bus3.data_o, 32'h0);
    check("t5_oor_valid", 32'(bus3.valid_o), 32'h1);
    check("t5_oor_err", 32'(bus3.sel_err_o), 32'(EXP_ERR));
    bus3.valid_i = 1'b0; bus3.flush_i = 1'b1; tick();
    check("t5_flush_valid", 32'(bus3.valid_o), 32'h0);
    check("t5_flush_err", 32'(bus3.sel_err_o), 32'(EXP_ERR));
    bus3.flush_i = 1'b0; tick();
    check("t5_sticky_err", 32'(bus3.sel_err_o), 32'(EXP_ERR));

    // 6: async reset while FULL
    bus4.ready_i = 1'b0; bus4.valid_i = 1'b1;
    bus4.select_i = 2'd3; tick();
    bus4.select_i = 2'd2; tick();
    check("t6_full", 32'(bus4.ready_o), 32'h0);
    check("t6_full_data", bus4.data_o, 32'hDDDD0003);
    bus4.valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(bus4.valid_o), 32'h0);
    check("t6_rst_data", bus4.data_o, 32'h0);
    check("t6_rst_ready", 32'(bus4.ready_o), 32'h1);
    check("t6_rst_selerr", 32'(bus3.sel_err_o), 32'h0);
    #2 rst_n = 1'b1;
    bus4.ready_i = 1'b1;
    tick();
    check("t6_post_valid", 32'(bus4.valid_o), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_n_pipe.md
Name: mux_n_pipe

Overview:
- Parametrised N-way operand-select stage with a registered output and valid/ready handshake.
- Successor to the combinational 2:1 32-bit selector.
- Placed between pipeline stages (e.g. EX operand forwarding select) so selection is decoupled from downstream stalls without dropping or duplicating words.
- Holds at most two words: an output register plus a skid register.

Parameters:
- WIDTH, 32, data word width in bits.
- NUM_IN, 4, number of data inputs (>= 2).
- SEL_W, $clog2(NUM_IN), select field width; derived, not overridden.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- data_i  input  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- select_i  input  SEL_W  binary index of the input to pass.
- valid_i  input  1  upstream word valid.
- ready_o  output  1  stage can accept a word this cycle.
- flush_i  input  1  synchronous discard of all held words.
- data_o  output  WIDTH  selected, registered word.
- valid_o  output  1  data_o is valid.
- ready_i  input  1  downstream accepts data_o this cycle.
- sel_err_o  output  1  sticky out-of-range select flag (only with MUXN_SEL_CHECK_EN).

Behaviour:
- Reset (rst_i=0, asynchronous):
  - data_o=0, valid_o=0, skid register cleared, skid-valid=0, sel_err_o=0.
  - ready_o=1 (it is !skid_valid, so it is 1 during and after reset).
- Accept: valid_i && ready_o at a clk_i edge.
  - The selected word is data_i[select_i*WIDTH +: WIDTH], sampled at that edge.
- Send: valid_o && ready_i at a clk_i edge.
- Latency: accepted word appears on data_o with valid_o=1 in the next cycle; no combinational path from data_i/select_i to data_o.
- ready_o = !skid_valid, purely from registered state; no combinational path from ready_i to ready_o.
- States, encoded by {skid_valid, valid_o}:
  - EMPTY (0,0):
    - accept -> ONE, data_o<=sel.
  - ONE (0,1):
    - accept & send -> ONE, data_o<=sel.
    - accept & !send -> FULL, skid<=sel, data_o held.
    - !accept & send -> EMPTY.
    - otherwise hold.
  - FULL (1,1): ready_o=0, no accept.
    - send -> ONE, data_o<=skid.
    - otherwise hold.
- Ordering is strict FIFO; no word is lost or repeated.
- data_o is stable while valid_o=1 and ready_i=0.
- Out-of-range select (select_i >= NUM_IN, possible only when NUM_IN is not a power of 2): the selected word is all zeros.
- flush_i=1:
  - Next edge clears valid_o and skid_valid; state becomes EMPTY.
  - Has priority over accept and send in the same cycle; the word offered that cycle is dropped.
  - data_o contents may remain but valid_o=0.
- valid_i while ready_o=0 is ignored; upstream must hold its word until ready_o=1.
- Reset asserted mid-transfer discards all held words immediately, without waiting for a clock edge.

Optional Feature:
- Macro: MUXN_SEL_CHECK_EN.
- Defined:
  - sel_err_o is set at the edge of any accept whose select_i >= NUM_IN.
  - It stays 1 until reset; flush_i does not clear it.
  - The word is still passed as zero.
- Undefined:
  - sel_err_o is tied to 0 and no check logic is built.
  - The out-of-range zero-select behaviour is unchanged.

Test Plan:
1. Reset, then NUM_IN=4, WIDTH=32, data_i={D3=0xDDDD0003, D2=0xCCCC0002, D1=0xBBBB0001, D0=0xAAAA0000}, select_i=2, valid_i=1 for one cycle, ready_i=1 -> next cycle data_o=0xCCCC0002, valid_o=1; following cycle valid_o=0.
2. Back-to-back stream, selects 0,1,2,3, ready_i=1 throughout -> data_o shows 0xAAAA0000, 0xBBBB0001, 0xCCCC0002, 0xDDDD0003 on consecutive cycles; ready_o stays 1.
3. Backpressure: ready_i=0, offer selects 1 then 3 -> state FULL, ready_o=0, data_o held at 0xBBBB0001. Raise ready_i -> 0xBBBB0001 sent, then 0xDDDD0003, then valid_o=0. A third word offered while ready_o=0 never appears.
4. flush_i=1 in FULL with valid_i=1 -> next cycle valid_o=0, ready_o=1; neither the held words nor the offered word are ever output.
5. NUM_IN=3, select_i=3 accepted -> data_o=0x00000000, valid_o=1. With MUXN_SEL_CHECK_EN, sel_err_o=1 from that edge and stays 1 after a flush; without the macro, sel_err_o=0.
6. rst_i pulled low between clock edges while FULL -> valid_o=0 and data_o=0 before the next edge; ready_o=1.
